// File: rtl/vga_timing_gen_if.sv
// Pixel stream carried between the timing generator and the drawing stages.
// All fields refer to the same pixel in any given cycle.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing source: counters, sync, blanking and frame_start, all registered together.
// Define VGA_TEST_PATTERN_EN to drive an 8-bar colour test pattern on rgb; otherwise rgb is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out,
  output logic frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  if (H_TOTAL > 2048) begin : gHTotalCheck
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : gVTotalCheck
    $error("vga_timing_gen: V_TOTAL exceeds 2048");
  end

  logic [10:0] hCount_q, hCount_d;
  logic [10:0] vCount_q, vCount_d;
  logic        hSync_q, hSync_d;
  logic        vSync_q, vSync_d;
  logic        hBlnk_q, hBlnk_d;
  logic        vBlnk_q, vBlnk_d;
  logic        frameStart_q, frameStart_d;

  always_comb begin
    hCount_d = hCount_q + 11'd1;
    vCount_d = vCount_q;
    if (hCount_q == H_LAST) begin
      hCount_d = '0;
      vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + 11'd1;
    end
  end

  // Decoding from the next-state counters lets every field land in the same register stage.
  always_comb begin
    hBlnk_d      = int'(hCount_d) >= H_ACTIVE;
    vBlnk_d      = int'(vCount_d) >= V_ACTIVE;
    hSync_d      = (int'(hCount_d) >= H_ACTIVE + H_FP) &&
                   (int'(hCount_d) <  H_ACTIVE + H_FP + H_SYNC);
    vSync_d      = (int'(vCount_d) >= V_ACTIVE + V_FP) &&
                   (int'(vCount_d) <  V_ACTIVE + V_FP + V_SYNC);
    frameStart_d = (hCount_d == '0) && (vCount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hCount_q     <= '0;
      vCount_q     <= '0;
      hSync_q      <= 1'b0;
      vSync_q      <= 1'b0;
      hBlnk_q      <= 1'b0;
      vBlnk_q      <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      hBlnk_q      <= hBlnk_d;
      vBlnk_q      <= vBlnk_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga_out.hcount = hCount_q;
  assign vga_out.vcount = vCount_q;
  assign vga_out.hsync  = hSync_q;
  assign vga_out.vsync  = vSync_q;
  assign vga_out.hblnk  = hBlnk_q;
  assign vga_out.vblnk  = vBlnk_q;
  assign frame_start    = frameStart_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  if (H_ACTIVE < 8) begin : gBarWidthCheck
    $error("vga_timing_gen: H_ACTIVE too small for 8 colour bars");
  end

  logic [11:0] rgb_q, rgb_d;

  // Pixels past the eighth full bar (H_ACTIVE not a multiple of 8) fall into the default black.
  always_comb begin
    rgb_d = 12'h000;
    if (!hBlnk_d && !vBlnk_d) begin
      case (int'(hCount_d) / BAR_W)
        0:       rgb_d = 12'hFFF;
        1:       rgb_d = 12'hFF0;
        2:       rgb_d = 12'h0FF;
        3:       rgb_d = 12'h0F0;
        4:       rgb_d = 12'hF0F;
        5:       rgb_d = 12'hF00;
        6:       rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vga_out.rgb = rgb_q;
`else
  assign vga_out.rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced video mode so full frames stay short.
// Expected pixels come from a position model driven by cycles elapsed since reset release.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        fs;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frameStart;

  vga_if vif ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_out    (vif),
    .frame_start(frameStart)
  );

  always #5 clk = ~clk;

  pix_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   pIdx   = 0;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] barColour(int idx);
    case (idx)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction
`endif

  // p counts output pixels since the reset state (p = 0 is pixel (0,0) held by reset).
  function automatic pix_t modelPixel(int p);
    pix_t e;
    int q, h, v;
    q = p % FT;
    h = q % HT;
    v = q / HT;
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.hs  = (h >= HA + HF) && (h < HA + HF + HS);
    e.vs  = (v >= VA + VF) && (v < VA + VF + VS);
    e.hb  = h >= HA;
    e.vb  = v >= VA;
    e.fs  = (p > 0) && (q == 0);
    e.rgb = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (h < HA && v < VA) e.rgb = barColour(h / (HA / 8));
`endif
    return e;
  endfunction

  function automatic pix_t sampleDut();
    return {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, frameStart};
  endfunction

  task automatic driveCycle(input logic r);
    rst = r;
    @(posedge clk);
    if (r) begin
      pIdx = 0;
      expQ.push_back('0);
    end else begin
      pIdx++;
      expQ.push_back(modelPixel(pIdx));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    pix_t exp, act;
    for (int i = 0; i < 5; i++) begin
      driveCycle(1'b1);
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act !== exp) begin errors++; $display("[TB] FAIL reset_state got=%h want=%h", act, exp); end
    end
    driveCycle(1'b0);
    exp = expQ.pop_front(); act = sampleDut(); checks++;
    if (act !== exp) begin errors++; $display("[TB] FAIL release_pixel got=%h want=%h", act, exp); end
    checks++;
    if ({act.h, act.v, act.hb} !== {11'd1, 11'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL release_position got h=%0d v=%0d hb=%b want h=1 v=0 hb=0", act.h, act.v, act.hb);
    end
  endtask

  task automatic test_line();
    pix_t exp, act, prev;
    int hbRiseAt = -1, hsFirst = -1, hsCount = 0, wrapSeen = 0;
    prev = sampleDut();
    for (int i = 0; i < HT; i++) begin
      driveCycle(1'b0);
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act !== exp) begin errors++; $display("[TB] FAIL line_pixel got=%h want=%h", act, exp); end
      if (act.hb && !prev.hb && hbRiseAt < 0) hbRiseAt = int'(act.h);
      if (act.hs && act.v == 11'd0) begin
        if (hsFirst < 0) hsFirst = int'(act.h);
        hsCount++;
      end
      if (prev.h == 11'(HT - 1)) begin
        wrapSeen++;
        checks++;
        if ({act.h, act.v} !== {11'd0, 11'd1}) begin
          errors++;
          $display("[TB] FAIL line_wrap got h=%0d v=%0d want h=0 v=1", act.h, act.v);
        end
      end
      prev = act;
    end
    checks++;
    if (hbRiseAt !== HA) begin errors++; $display("[TB] FAIL hblnk_rise got=%0d want=%0d", hbRiseAt, HA); end
    checks++;
    if (hsFirst !== HA + HF) begin errors++; $display("[TB] FAIL hsync_start got=%0d want=%0d", hsFirst, HA + HF); end
    checks++;
    if (hsCount !== HS) begin errors++; $display("[TB] FAIL hsync_width got=%0d want=%0d", hsCount, HS); end
    checks++;
    if (wrapSeen !== 1) begin errors++; $display("[TB] FAIL wrap_count got=%0d want=1", wrapSeen); end
  endtask

  task automatic test_frame();
    pix_t exp, act, prev;
    int vbRiseAt = -1, vsFirst = -1, vsLines = 0, fsCount = 0, fsAt = -1;
    prev = sampleDut();
    for (int i = 0; i < FT; i++) begin
      driveCycle(1'b0);
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act !== exp) begin errors++; $display("[TB] FAIL frame_pixel got=%h want=%h", act, exp); end
      if (act.vb && !prev.vb && vbRiseAt < 0) vbRiseAt = int'(act.v);
      if (act.vs && act.h == 11'd0) begin
        if (vsFirst < 0) vsFirst = int'(act.v);
        vsLines++;
      end
      if (act.fs) begin
        fsCount++;
        fsAt = pIdx;
      end
      prev = act;
    end
    checks++;
    if (vbRiseAt !== VA) begin errors++; $display("[TB] FAIL vblnk_rise got=%0d want=%0d", vbRiseAt, VA); end
    checks++;
    if (vsFirst !== VA + VF) begin errors++; $display("[TB] FAIL vsync_start got=%0d want=%0d", vsFirst, VA + VF); end
    checks++;
    if (vsLines !== VS) begin errors++; $display("[TB] FAIL vsync_lines got=%0d want=%0d", vsLines, VS); end
    checks++;
    if (fsCount !== 1) begin errors++; $display("[TB] FAIL frame_start_count got=%0d want=1", fsCount); end
    checks++;
    if (fsAt !== FT) begin errors++; $display("[TB] FAIL frame_start_cycle got=%0d want=%0d", fsAt, FT); end
  endtask

  task automatic test_mid_reset();
    pix_t exp, act;
    int guard = 0;
    while ((pIdx % FT) != 5 * HT + 12 && guard < 2 * FT) begin
      driveCycle(1'b0);
      guard++;
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act !== exp) begin errors++; $display("[TB] FAIL seek_pixel got=%h want=%h", act, exp); end
    end
    checks++;
    if (guard >= 2 * FT) begin errors++; $display("[TB] FAIL seek_timeout got=%0d want<%0d", guard, 2 * FT); end
    driveCycle(1'b1);
    exp = expQ.pop_front(); act = sampleDut(); checks++;
    if (act !== exp) begin errors++; $display("[TB] FAIL mid_reset_pixel got=%h want=%h", act, exp); end
    checks++;
    if (act !== pix_t'(0)) begin errors++; $display("[TB] FAIL mid_reset_zero got=%h want=0", act); end
    for (int i = 0; i < 2 * HT; i++) begin
      driveCycle(1'b0);
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act !== exp) begin errors++; $display("[TB] FAIL resume_pixel got=%h want=%h", act, exp); end
    end
  endtask

  task automatic test_pattern();
    pix_t exp, act;
    int guard = 0;
    while ((pIdx % FT) != 3 * HT - 1 && guard < 2 * FT) begin
      driveCycle(1'b0);
      guard++;
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act !== exp) begin errors++; $display("[TB] FAIL seek_pixel got=%h want=%h", act, exp); end
    end
    checks++;
    if (guard >= 2 * FT) begin errors++; $display("[TB] FAIL seek_timeout got=%0d want<%0d", guard, 2 * FT); end
    for (int i = 0; i < HT; i++) begin
      driveCycle(1'b0);
      exp = expQ.pop_front(); act = sampleDut(); checks++;
      if (act.rgb !== exp.rgb || act.v !== 11'd3) begin
        errors++;
        $display("[TB] FAIL pattern_rgb h=%0d v=%0d got=%h want=%h", act.h, act.v, act.rgb, exp.rgb);
      end
    end
  endtask

  initial begin
    $display("[TB] starting vga_timing_gen bench, frame of %0d cycles", FT);
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_pattern();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
